// File: rtl/exec_mulx_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exec_mulx_seq: multi-cycle signed/unsigned multiplier, low/high select     |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module exec_mulx_seq #(
  parameter int W_OPR          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int W_FLAGS        = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [W_OPR-1:0]   opr0_i,
  input  logic [W_OPR-1:0]   opr1_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [W_OPR-1:0]   result_o,
  output logic [W_FLAGS-1:0] flags_o
);

  localparam int c_iters = W_OPR / BITS_PER_CYCLE;
  localparam int c_cnt_w = $clog2(c_iters + 1);
  localparam int c_w_p   = 2 * W_OPR;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_iters - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_fix  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [c_w_p-1:0]   mcand_q, mcand_d;
  logic [W_OPR-1:0]   mplr_q, mplr_d;
  logic [c_w_p-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [1:0]         mode_q, mode_d;
  logic               valid_q, valid_d;
  logic [W_OPR-1:0]   result_q, result_d;
  logic [W_FLAGS-1:0] flags_q, flags_d;

  logic               w_accept;
  logic               w_zero_opr;
  logic [W_OPR-1:0]   w_mag0, w_mag1;
  logic [c_w_p-1:0]   w_pp;
  logic [W_OPR-1:0]   w_hi, w_lo, w_res;
  logic               w_carry;
  logic [W_FLAGS-1:0] w_flags;

  assign w_accept   = (state_q == c_st_idle) && start_i && !flush_i;
  assign w_zero_opr = (opr0_i == '0) || (opr1_i == '0);
  // Magnitudes stay W_OPR-bit unsigned, so the most negative input maps to 2^(W_OPR-1).
  assign w_mag0 = (mode_i[0] && opr0_i[W_OPR-1]) ? -opr0_i : opr0_i;
  assign w_mag1 = (mode_i[0] && opr1_i[W_OPR-1]) ? -opr1_i : opr1_i;

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplr_q[i]) w_pp = w_pp + (mcand_q << i);
    end
  end

  assign w_hi  = acc_q[c_w_p-1:W_OPR];
  assign w_lo  = acc_q[W_OPR-1:0];
  assign w_res = mode_q[1] ? w_hi : w_lo;

  always_comb begin
    case (mode_q)
      2'b00:   w_carry = (w_hi != '0);
      2'b01:   w_carry = (w_hi != {W_OPR{w_lo[W_OPR-1]}});
      default: w_carry = 1'b0;
    endcase
    w_flags = {(mode_q == 2'b01) && w_carry, w_res[W_OPR-1], w_res == '0, w_carry};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= c_st_idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (w_accept) state_d = w_zero_opr ? c_st_done : c_st_calc;
      c_st_calc: begin
        if (flush_i)                  state_d = c_st_idle;
        else if (cnt_q == c_cnt_last) state_d = c_st_fix;
      end
      c_st_fix:  state_d = flush_i ? c_st_idle : c_st_done;
      default:   state_d = c_st_idle;
    endcase
  end

  always_comb begin
    ready_o = (state_q == c_st_idle);
  end

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    mode_d   = mode_q;
    valid_d  = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      c_st_idle: if (w_accept) begin
        mode_d  = mode_i;
        neg_d   = mode_i[0] && (opr0_i[W_OPR-1] ^ opr1_i[W_OPR-1]);
        mcand_d = {{W_OPR{1'b0}}, w_mag0};
        mplr_d  = w_mag1;
        acc_d   = '0;
        cnt_d   = '0;
      end
      c_st_calc: if (!flush_i) begin
        acc_d   = acc_q + w_pp;
        mcand_d = mcand_q << BITS_PER_CYCLE;
        mplr_d  = mplr_q >> BITS_PER_CYCLE;
        cnt_d   = cnt_q + c_cnt_w'(1);
      end
      c_st_fix: if (!flush_i && neg_q) acc_d = -acc_q;
      default: if (!flush_i) begin
        valid_d  = 1'b1;
        result_d = w_res;
        flags_d  = w_flags;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      mode_q   <= 2'b00;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      mode_q   <= mode_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_mulx_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exec_mulx_seq: bench for exec_mulx_seq at 1, 2, 4 and 8 bits per cycle  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_exec_mulx_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic [3:0]        r_ready, r_valid;
  logic [3:0][31:0]  r_res;
  logic [3:0][3:0]   r_flg;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_dut
      exec_mulx_seq #(.W_OPR(W), .BITS_PER_CYCLE(1 << k), .W_FLAGS(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .opr0_i(a), .opr1_i(b), .flush_i(flush),
        .ready_o(r_ready[k]), .valid_o(r_valid[k]),
        .result_o(r_res[k]), .flags_o(r_flg[k]));
    end
  endgenerate

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Reference: exact product via 64-bit arithmetic, flags from range tests.
  function automatic void calc(input logic [1:0] md, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] r, output logic [3:0] f);
    logic [63:0] p;
    longint sx, sy, sp;
    logic c;
    if (md[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = 64'(sx * sy);
    end else begin
      p = {32'b0, x} * {32'b0, y};
    end
    sp = longint'(p);
    r  = md[1] ? p[63:32] : p[31:0];
    case (md)
      2'b00:   c = (p > 64'hFFFF_FFFF);
      2'b01:   c = (sp > SMAX) || (sp < SMIN);
      default: c = 1'b0;
    endcase
    f = {(md == 2'b01) && c, r[31], r == 32'h0, c};
  endfunction

  bit          m_on = 1'b0;
  bit          m_busy[4];
  int          m_left[4];
  bit          m_vld[4];
  logic [31:0] m_res[4], m_pres[4];
  logic [3:0]  m_flg[4], m_pflg[4];

  always @(posedge clk) begin
    logic [31:0] tr;
    logic [3:0]  tf;
    if (rst) begin
      m_on = 1'b1;
      for (int k = 0; k < 4; k++) begin
        m_busy[k] = 1'b0; m_vld[k] = 1'b0; m_res[k] = '0; m_flg[k] = '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_vld[k] = 1'b0;
        if (m_busy[k]) begin
          if (flush) m_busy[k] = 1'b0;
          else begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_busy[k] = 1'b0; m_vld[k] = 1'b1;
              m_res[k] = m_pres[k]; m_flg[k] = m_pflg[k];
            end
          end
        end else if (start && !flush) begin
          calc(mode, a, b, tr, tf);
          m_pres[k] = tr; m_pflg[k] = tf;
          m_busy[k] = 1'b1;
          m_left[k] = (a == 0 || b == 0) ? 1 : (W >> k) + 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("valid[%0d]", k), r_valid[k], m_vld[k]);
        check($sformatf("ready[%0d]", k), r_ready[k], !m_busy[k]);
        check($sformatf("result[%0d]", k), r_res[k], m_res[k]);
        check($sformatf("flags[%0d]", k), r_flg[k], m_flg[k]);
      end
    end
  end

  task automatic do_start(input logic [1:0] md, input logic [31:0] x, input logic [31:0] y);
    mode = md; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (r_valid[0]) break;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] md, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic [3:0] ef,
                        input int lat);
    int cyc;
    do_start(md, x, y);
    wait_valid(cyc);
    check({nm, " latency"}, cyc, lat);
    check({nm, " result"}, r_res[0], er);
    check({nm, " flags"}, r_flg[0], ef);
  endtask

  task automatic count_valid(input int n, output int nv);
    nv = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (r_valid[0]) nv++;
    end
  endtask

  initial begin
    logic [31:0] tr;
    logic [3:0]  tf;
    logic [31:0] spec[5];
    logic [31:0] x, y;
    int cyc, nv;

    calc(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, tr, tf);
    check("pin ul res", tr, 32'h1);        check("pin ul flg", tf, 4'b0001);
    calc(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, tr, tf);
    check("pin uh res", tr, 32'hFFFFFFFE); check("pin uh flg", tf, 4'b0100);
    calc(2'b01, 32'h80000000, 32'hFFFFFFFF, tr, tf);
    check("pin sl res", tr, 32'h80000000); check("pin sl flg", tf, 4'b1101);
    calc(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, tr, tf);
    check("pin sh res", tr, 32'h0);        check("pin sh flg", tf, 4'b0010);
    calc(2'b01, 32'd7, 32'hFFFFFFFD, tr, tf);
    check("pin sl2 res", tr, 32'hFFFFFFEB); check("pin sl2 flg", tf, 4'b0100);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst ready", r_ready[0], 1'b1);
    check("rst valid", r_valid[0], 1'b0);
    check("rst result", r_res[0], 32'h0);
    check("rst flags", r_flg[0], 4'h0);

    run_op("ul max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 4'b0001, 34);
    run_op("uh max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 34);
    run_op("sl minneg", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1101, 34);
    run_op("sh m1m1", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'b0010, 34);
    run_op("zero exit", 2'b00, 32'h0, 32'h1234, 32'h0, 4'b0010, 1);
    run_op("b2b sl", 2'b01, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0100, 34);

    // Flush lands in the cycle the BPC=1 instance sits in its negate state.
    do_start(2'b00, 32'd3, 32'd5);
    repeat (32) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush ready", r_ready[0], 1'b1);
    count_valid(40, nv);
    check("flush no valid", nv, 0);
    check("flush result kept", r_res[0], 32'hFFFFFFEB);
    check("flush flags kept", r_flg[0], 4'b0100);

    mode = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (r_valid[0]) nv++;
      if (i == 5) a = 32'd9;
      if (i == 19) start = 1'b0;
    end
    check("busy one valid", nv, 1);
    check("busy result", r_res[0], 32'd42);
    check("busy flags", r_flg[0], 4'b0000);
    repeat (30) @(posedge clk);
    #1;

    do_start(2'b00, 32'd5, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst ready", r_ready[0], 1'b1);
    check("midrst valid", r_valid[0], 1'b0);
    check("midrst result", r_res[0], 32'h0);
    check("midrst flags", r_flg[0], 4'h0);
    count_valid(40, nv);
    check("midrst no valid", nv, 0);

    spec = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 48; i++) begin
      x = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
      do_start(2'(i % 4), x, y);
      wait_valid(cyc);
      check($sformatf("sweep%0d latency", i), cyc, (x == 0 || y == 0) ? 1 : 34);
    end
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
